// File: rtl/vending_machine_if.sv
// Coin-acceptor inputs and dispenser/display outputs of the candy vending controller.
interface vending_machine_if;
  logic       N;
  logic       D;
  logic       Q;
  logic       Candy;
  logic [5:0] Number;

  modport master (output N, output D, output Q, input Candy, input Number);
  modport slave  (input N, input D, input Q, output Candy, output Number);
endinterface

// File: rtl/vending_machine.sv
// Single-product candy vending controller: accumulates coin credit and dispenses at PRICE.
// Optional VM_COIN_EDGE_EN: a coin counts only on the edge its one-hot pattern first appears.
module vending_machine #(
  parameter int unsigned PRICE = 25
) (
  input  logic              Clk,
  input  logic              Reset,
  vending_machine_if.slave  bus
);

  localparam int unsigned DATA_W  = 6;
  localparam logic [DATA_W-1:0] PRICE_C = DATA_W'(PRICE);

  typedef enum logic {IDLE, DISPENSE} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] credit_q, credit_d;
  logic [DATA_W-1:0] number_q, number_d;
  logic              candy_q, candy_d;
  logic [2:0]        coin_p0;
  logic [DATA_W-1:0] value;
  logic [DATA_W-1:0] sum;

  function automatic logic [DATA_W-1:0] coin_value(input logic [2:0] c);
    case (c)
      3'b100:  coin_value = DATA_W'(5);
      3'b010:  coin_value = DATA_W'(10);
      3'b001:  coin_value = DATA_W'(25);
      default: coin_value = '0;
    endcase
  endfunction

  assign coin_p0 = {bus.N, bus.D, bus.Q};

`ifdef VM_COIN_EDGE_EN
  logic [2:0] coin_p1;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) coin_p1 <= '0;
    else        coin_p1 <= coin_p0;
  end

  // A pattern identical to the previous sample is a held coin, not a new insert.
  assign value = (coin_p0 != coin_p1) ? coin_value(coin_p0) : '0;
`else
  logic unused_edge;
  assign unused_edge = 1'b0;
  assign value = coin_value(coin_p0);
`endif

  assign sum = credit_q + value;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= IDLE;
      credit_q <= '0;
      number_q <= '0;
      candy_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      number_q <= number_d;
      candy_q  <= candy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    number_d = credit_q;
    candy_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (value != '0) begin
          if (sum >= PRICE_C) begin
            state_d  = DISPENSE;
            credit_d = '0;
            number_d = sum - PRICE_C;
            candy_d  = 1'b1;
          end else begin
            credit_d = sum;
            number_d = sum;
          end
        end
      end
      DISPENSE: begin
        // Coins arriving on the return edge are dropped.
        state_d  = IDLE;
        credit_d = '0;
        number_d = '0;
      end
      default: begin
        state_d  = IDLE;
        credit_d = '0;
        number_d = '0;
      end
    endcase
  end

  assign bus.Candy  = candy_q;
  assign bus.Number = number_q;

endmodule

// File: tb/tb_vending_machine.sv
// Directed bench for vending_machine with a cents-level behavioural model checked every cycle.
module tb_vending_machine;

  localparam int PRICE = 25;

  logic Clk;
  logic Reset;
  int   checks;
  int   errors;

  int   m_credit;
  bit   m_disp;
  bit [2:0] m_prev;
  bit   exp_candy;
  int   exp_number;

  vending_machine_if vif ();

  vending_machine #(.PRICE(PRICE)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (vif)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Every cycle: DUT outputs must equal what the model says they are.
  always @(negedge Clk) begin
    check("model_candy", int'(vif.Candy), int'(exp_candy));
    check("model_number", int'(vif.Number), exp_number);
  end

  function automatic int cents(input bit n, input bit d, input bit q);
    if ((int'(n) + int'(d) + int'(q)) != 1) return 0;
    if (n) return 5;
    if (d) return 10;
    return 25;
  endfunction

  // Drive one coin pattern for one rising edge; returns at the following falling edge.
  task automatic step(input bit n, input bit d, input bit q);
    int  v;
    int  total;
    bit  nc;
    int  nn;
    vif.N = n;
    vif.D = d;
    vif.Q = q;
    v = cents(n, d, q);
`ifdef VM_COIN_EDGE_EN
    if ({n, d, q} == m_prev) v = 0;
`endif
    m_prev = {n, d, q};
    nc = 1'b0;
    if (m_disp) begin
      m_disp   = 1'b0;
      m_credit = 0;
      nn       = 0;
    end else if (v == 0) begin
      nn = m_credit;
    end else begin
      total = m_credit + v;
      if (total >= PRICE) begin
        m_disp   = 1'b1;
        nc       = 1'b1;
        nn       = total - PRICE;
        m_credit = 0;
      end else begin
        m_credit = total;
        nn       = total;
      end
    end
    @(posedge Clk);
    exp_candy  = nc;
    exp_number = nn;
    @(negedge Clk);
  endtask

  task automatic lit(input string name, input int candy, input int number);
    check({name, "_candy"}, int'(vif.Candy), candy);
    check({name, "_number"}, int'(vif.Number), number);
  endtask

  task automatic assert_reset();
    m_credit   = 0;
    m_disp     = 1'b0;
    m_prev     = 3'b000;
    exp_candy  = 1'b0;
    exp_number = 0;
    Reset      = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    vif.N = 1'b0;
    vif.D = 1'b0;
    vif.Q = 1'b0;
    m_credit = 0;
    m_disp = 1'b0;
    m_prev = 3'b000;
    exp_candy = 1'b0;
    exp_number = 0;
    Reset = 1'b1;
    #1;
    assert_reset();
    repeat (3) @(negedge Clk);
    lit("reset", 0, 0);
    Reset = 1'b1;
    step(0, 0, 0);
    step(0, 0, 0);
    lit("idle", 0, 0);

    // Single quarter buys exactly, then dispense returns to zero.
    step(0, 0, 1);
    lit("quarter", 1, 0);
    step(0, 0, 0);
    lit("after_quarter", 0, 0);

    // Multi-bit pattern is ignored.
    step(1, 1, 0);
    lit("nd_together", 0, 0);
    step(1, 1, 1);
    lit("ndq_together", 0, 0);
    step(0, 0, 0);

    // Nickel then quarter gives 5 change.
    step(1, 0, 0);
    lit("nickel", 0, 5);
    step(0, 0, 1);
    lit("nq_dispense", 1, 5);
    step(0, 0, 0);
    lit("nq_after", 0, 0);

    // Dime, nickel, then asynchronous reset mid-cycle.
    step(0, 1, 0);
    lit("dime", 0, 10);
    step(1, 0, 0);
    lit("dime_nickel", 0, 15);
    #2;
    assert_reset();
    #1;
    lit("async_reset", 0, 0);
    @(negedge Clk);
    Reset = 1'b1;
    step(0, 0, 0);
    lit("post_reset", 0, 0);

    // Dime, idle, dime, nickel reaches the price exactly.
    step(0, 1, 0);
    step(0, 0, 0);
    lit("ddn_hold", 0, 10);
    step(0, 1, 0);
    lit("ddn_20", 0, 20);
    step(1, 0, 0);
    lit("ddn_dispense", 1, 0);
    step(0, 0, 0);

    // Largest change: 20 credit plus a quarter.
    step(0, 1, 0);
    step(0, 0, 0);
    step(0, 1, 0);
    step(0, 0, 1);
    lit("max_change", 1, 20);
    // Coin on the dispense-return edge is dropped.
    step(1, 0, 0);
    lit("coin_in_dispense", 0, 0);
    step(0, 0, 0);
    lit("coin_dropped", 0, 0);

    // Dime held for three edges.
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 1, 0);
`ifdef VM_COIN_EDGE_EN
    lit("dime_held", 0, 10);
`else
    lit("dime_held", 1, 5);
`endif
    step(0, 0, 0);

    // Mixed table, checked by the model only.
    step(0, 0, 1);
    step(0, 0, 1);
    step(1, 0, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    step(0, 1, 0);
    step(0, 1, 1);
    step(0, 0, 1);
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
